// File: rtl/writeback_arbiter.sv
// Two-slot result broadcast arbiter: one holding buffer per producer, round-robin
// selection of up to two buffered results per cycle onto registered bus outputs.
module writeback_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic                      bus0_valid,
    output logic                      bus1_valid,
    output logic [TAG_W-1:0]          bus0_tag,
    output logic [TAG_W-1:0]          bus1_tag,
    output logic [ROB_W-1:0]          bus0_rob,
    output logic [ROB_W-1:0]          bus1_rob,
    output logic [DATA_W-1:0]         bus0_value,
    output logic [DATA_W-1:0]         bus1_value,
    output logic [1:0]                bus0_src,
    output logic [1:0]                bus1_src,
    output logic [15:0]               conflict_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0]             buf_valid_q, buf_valid_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag_q, buf_tag_d;
    logic [NUM_REQ-1:0][ROB_W-1:0]  buf_rob_q, buf_rob_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] buf_value_q, buf_value_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic [15:0]                    conflict_q, conflict_d;
    logic                           bus0_valid_q, bus0_valid_d, bus1_valid_q, bus1_valid_d;
    logic [TAG_W-1:0]               bus0_tag_q, bus0_tag_d, bus1_tag_q, bus1_tag_d;
    logic [ROB_W-1:0]               bus0_rob_q, bus0_rob_d, bus1_rob_q, bus1_rob_d;
    logic [DATA_W-1:0]              bus0_value_q, bus0_value_d, bus1_value_q, bus1_value_d;
    logic [1:0]                     bus0_src_q, bus0_src_d, bus1_src_q, bus1_src_d;

    logic [CNT_W-1:0]               occ_cnt_s;
    logic [PTR_W-1:0]               idx_s, grant_a_idx_s, grant_b_idx_s, last_idx_s;
    logic                           grant_a_vld_s, grant_b_vld_s;
    logic [NUM_REQ-1:0]             granted_s, req_ready_s;

    // Round-robin scan from ptr over registered occupancy; also counts occupied buffers.
    always_comb begin
        occ_cnt_s     = {CNT_W{1'b0}};
        idx_s         = {PTR_W{1'b0}};
        grant_a_idx_s = {PTR_W{1'b0}};
        grant_b_idx_s = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            grant_a_idx_s = (buf_valid_q[idx_s] && occ_cnt_s == CNT_W'(0)) ? idx_s : grant_a_idx_s;
            grant_b_idx_s = (buf_valid_q[idx_s] && occ_cnt_s == CNT_W'(1)) ? idx_s : grant_b_idx_s;
            occ_cnt_s     = occ_cnt_s + {{PTR_W{1'b0}}, buf_valid_q[idx_s]};
        end
        grant_a_vld_s = (occ_cnt_s >= CNT_W'(1));
        grant_b_vld_s = (occ_cnt_s >= CNT_W'(2));
        last_idx_s    = grant_b_vld_s ? grant_b_idx_s : grant_a_idx_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            granted_s[i] = (grant_a_vld_s && grant_a_idx_s == PTR_W'(i)) ||
                           (grant_b_vld_s && grant_b_idx_s == PTR_W'(i));
        end
        req_ready_s = {NUM_REQ{~flush}} & (~buf_valid_q | granted_s);
    end

    assign req_ready = req_ready_s;

    // Buffer capture/clear: a granted buffer may be refilled on the same edge.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_rob_d   = buf_rob_q;
        buf_value_d = buf_value_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                buf_valid_d[i] = 1'b0;
            end else if (req_valid[i] && req_ready_s[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_tag_d[i]   = req_tag[i*TAG_W +: TAG_W];
                buf_rob_d[i]   = req_rob[i*ROB_W +: ROB_W];
                buf_value_d[i] = req_value[i*DATA_W +: DATA_W];
            end else if (granted_s[i]) begin
                buf_valid_d[i] = 1'b0;
            end else begin
                buf_valid_d[i] = buf_valid_q[i];
            end
        end
    end

    // Next bus contents, pointer and saturating conflict counter.
    always_comb begin
        bus0_valid_d = ~flush & grant_a_vld_s;
        bus1_valid_d = ~flush & grant_b_vld_s;
        bus0_tag_d   = bus0_valid_d ? buf_tag_q[grant_a_idx_s]   : {TAG_W{1'b0}};
        bus0_rob_d   = bus0_valid_d ? buf_rob_q[grant_a_idx_s]   : {ROB_W{1'b0}};
        bus0_value_d = bus0_valid_d ? buf_value_q[grant_a_idx_s] : {DATA_W{1'b0}};
        bus0_src_d   = bus0_valid_d ? 2'(grant_a_idx_s)          : 2'b00;
        bus1_tag_d   = bus1_valid_d ? buf_tag_q[grant_b_idx_s]   : {TAG_W{1'b0}};
        bus1_rob_d   = bus1_valid_d ? buf_rob_q[grant_b_idx_s]   : {ROB_W{1'b0}};
        bus1_value_d = bus1_valid_d ? buf_value_q[grant_b_idx_s] : {DATA_W{1'b0}};
        bus1_src_d   = bus1_valid_d ? 2'(grant_b_idx_s)          : 2'b00;
        if (flush) begin
            ptr_d = {PTR_W{1'b0}};
        end else if (!grant_a_vld_s) begin
            ptr_d = ptr_q;
        end else if (last_idx_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_d = {PTR_W{1'b0}};
        end else begin
            ptr_d = last_idx_s + PTR_W'(1);
        end
        conflict_d = (occ_cnt_s > CNT_W'(2) && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;
    end

    // State registers; asynchronous active-low reset discards everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q  <= {NUM_REQ{1'b0}};
            buf_tag_q    <= '{default: {TAG_W{1'b0}}};
            buf_rob_q    <= '{default: {ROB_W{1'b0}}};
            buf_value_q  <= '{default: {DATA_W{1'b0}}};
            ptr_q        <= {PTR_W{1'b0}};
            conflict_q   <= 16'd0;
            bus0_valid_q <= 1'b0;
            bus1_valid_q <= 1'b0;
            bus0_tag_q   <= {TAG_W{1'b0}};
            bus1_tag_q   <= {TAG_W{1'b0}};
            bus0_rob_q   <= {ROB_W{1'b0}};
            bus1_rob_q   <= {ROB_W{1'b0}};
            bus0_value_q <= {DATA_W{1'b0}};
            bus1_value_q <= {DATA_W{1'b0}};
            bus0_src_q   <= 2'b00;
            bus1_src_q   <= 2'b00;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            buf_rob_q    <= buf_rob_d;
            buf_value_q  <= buf_value_d;
            ptr_q        <= ptr_d;
            conflict_q   <= conflict_d;
            bus0_valid_q <= bus0_valid_d;
            bus1_valid_q <= bus1_valid_d;
            bus0_tag_q   <= bus0_tag_d;
            bus1_tag_q   <= bus1_tag_d;
            bus0_rob_q   <= bus0_rob_d;
            bus1_rob_q   <= bus1_rob_d;
            bus0_value_q <= bus0_value_d;
            bus1_value_q <= bus1_value_d;
            bus0_src_q   <= bus0_src_d;
            bus1_src_q   <= bus1_src_d;
        end
    end

    assign bus0_valid     = bus0_valid_q;
    assign bus1_valid     = bus1_valid_q;
    assign bus0_tag       = bus0_tag_q;
    assign bus1_tag       = bus1_tag_q;
    assign bus0_rob       = bus0_rob_q;
    assign bus1_rob       = bus1_rob_q;
    assign bus0_value     = bus0_value_q;
    assign bus1_value     = bus1_value_q;
    assign bus0_src       = bus0_src_q;
    assign bus1_src       = bus1_src_q;
    assign conflict_count = conflict_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter: reset, single producer, full contention,
// backpressure, flush and asynchronous reset mid-stream.
module tb_writeback_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int ROB_W   = 6;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*ROB_W-1:0]  req_rob;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic                      bus0_valid, bus1_valid;
    logic [TAG_W-1:0]          bus0_tag, bus1_tag;
    logic [ROB_W-1:0]          bus0_rob, bus1_rob;
    logic [DATA_W-1:0]         bus0_value, bus1_value;
    logic [1:0]                bus0_src, bus1_src;
    logic [15:0]               conflict_count;

    int n_vec  = 0;
    int n_miss = 0;

    writeback_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_rob(req_rob), .req_value(req_value),
        .bus0_valid(bus0_valid), .bus1_valid(bus1_valid),
        .bus0_tag(bus0_tag), .bus1_tag(bus1_tag),
        .bus0_rob(bus0_rob), .bus1_rob(bus1_rob),
        .bus0_value(bus0_value), .bus1_value(bus1_value),
        .bus0_src(bus0_src), .bus1_src(bus1_src),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W-1:0] exp_tag(input int i, input int s);
        return TAG_W'(i * 16 + s);
    endfunction

    function automatic logic [ROB_W-1:0] exp_rob(input int i, input int s);
        return ROB_W'(s * 4 + i);
    endfunction

    function automatic logic [DATA_W-1:0] exp_val(input int i, input int s);
        return 32'hA000_0000 | DATA_W'(i << 8) | DATA_W'(s);
    endfunction

    task automatic drive_slot(input int i, input int s);
        req_tag[i*TAG_W +: TAG_W]     = exp_tag(i, s);
        req_rob[i*ROB_W +: ROB_W]     = exp_rob(i, s);
        req_value[i*DATA_W +: DATA_W] = exp_val(i, s);
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        flush     = 1'b0;
        reset     = 1'b0;
        #2;
        reset     = 1'b1;
    endtask

    logic [3:0] rdy_tab [0:8];
    int         seq [0:3];
    logic [3:0] vin;
    int         ga, gs, exp_cnt;

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b0000;
        req_tag   = '0;
        req_rob   = '0;
        req_value = '0;
        rdy_tab   = '{4'b1111, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b1111, 4'b1111};

        // Reset state, then idle
        #2;
        check_vec("rst_bus0_valid", 64'(bus0_valid), 64'd0);
        check_vec("rst_bus1_valid", 64'(bus1_valid), 64'd0);
        check_vec("rst_conflict", 64'(conflict_count), 64'd0);
        reset = 1'b1;
        tick();
        tick();
        check_vec("idle_ready", 64'(req_ready), 64'hF);
        check_vec("idle_bus0_valid", 64'(bus0_valid), 64'd0);
        check_vec("idle_bus0_tag", 64'(bus0_tag), 64'd0);
        check_vec("idle_bus1_value", 64'(bus1_value), 64'd0);

        // fu1 only: tag 5, rob 3, value DEADBEEF
        req_tag[0 +: TAG_W]    = 6'd5;
        req_rob[0 +: ROB_W]    = 6'd3;
        req_value[0 +: DATA_W] = 32'hDEADBEEF;
        req_valid = 4'b0001;
        #1;
        check_vec("fu1_ready", 64'(req_ready), 64'hF);
        tick();
        req_valid = 4'b0000;
        check_vec("fu1_not_yet", 64'(bus0_valid), 64'd0);
        tick();
        check_vec("fu1_bus0_valid", 64'(bus0_valid), 64'd1);
        check_vec("fu1_bus0_tag", 64'(bus0_tag), 64'd5);
        check_vec("fu1_bus0_rob", 64'(bus0_rob), 64'd3);
        check_vec("fu1_bus0_value", 64'(bus0_value), 64'hDEADBEEF);
        check_vec("fu1_bus0_src", 64'(bus0_src), 64'd0);
        check_vec("fu1_bus1_valid", 64'(bus1_valid), 64'd0);
        tick();
        check_vec("fu1_once", 64'(bus0_valid), 64'd0);

        // fu1 streaming: one broadcast per cycle
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            req_value[0 +: DATA_W] = 32'(100 + k);
            tick();
            if (k >= 1) begin
                check_vec($sformatf("stream_valid_%0d", k), 64'(bus0_valid), 64'd1);
                check_vec($sformatf("stream_value_%0d", k), 64'(bus0_value), 64'(100 + k - 1));
                check_vec($sformatf("stream_bus1_%0d", k), 64'(bus1_valid), 64'd0);
            end
        end
        req_valid = 4'b0000;
        tick();
        check_vec("stream_last_value", 64'(bus0_value), 64'd103);
        tick();
        check_vec("stream_drained", 64'(bus0_valid), 64'd0);

        // All four producers every cycle: grants {0,1},{2,3},... and backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            drive_slot(i, 0);
        end
        for (int e = 1; e <= 9; e++) begin
            vin = (e <= 6) ? 4'b1111 : 4'b0000;
            req_valid = vin;
            #1;
            check_vec($sformatf("all_ready_e%0d", e), 64'(req_ready), 64'(rdy_tab[e-1]));
            tick();
            for (int i = 0; i < 4; i++) begin
                if (vin[i] && rdy_tab[e-1][i]) begin
                    seq[i]++;
                    drive_slot(i, seq[i]);
                end
            end
            exp_cnt = (e == 1) ? 0 : ((e <= 7) ? e - 1 : 6);
            check_vec($sformatf("all_conflict_e%0d", e), 64'(conflict_count), 64'(exp_cnt));
            if (e >= 2 && e <= 8) begin
                ga = (e % 2 == 0) ? 0 : 2;
                gs = (e - 2) / 2;
                check_vec($sformatf("all_b0v_e%0d", e), 64'(bus0_valid), 64'd1);
                check_vec($sformatf("all_b1v_e%0d", e), 64'(bus1_valid), 64'd1);
                check_vec($sformatf("all_b0src_e%0d", e), 64'(bus0_src), 64'(ga));
                check_vec($sformatf("all_b1src_e%0d", e), 64'(bus1_src), 64'(ga + 1));
                check_vec($sformatf("all_b0val_e%0d", e), 64'(bus0_value), 64'(exp_val(ga, gs)));
                check_vec($sformatf("all_b1val_e%0d", e), 64'(bus1_value), 64'(exp_val(ga + 1, gs)));
                check_vec($sformatf("all_b0tag_e%0d", e), 64'(bus0_tag), 64'(exp_tag(ga, gs)));
                check_vec($sformatf("all_b1rob_e%0d", e), 64'(bus1_rob), 64'(exp_rob(ga + 1, gs)));
            end else begin
                check_vec($sformatf("all_idle_e%0d", e), 64'({bus0_valid, bus1_valid}), 64'd0);
            end
        end

        // Flush with three buffers full and a non-zero pointer
        do_reset();
        drive_slot(2, 0);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        check_vec("fl_pre_src", 64'(bus0_src), 64'd2);
        for (int i = 0; i < 3; i++) drive_slot(i, 1);
        req_valid = 4'b0111;
        tick();
        req_valid = 4'b0000;
        flush = 1'b1;
        #1;
        check_vec("fl_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        check_vec("fl_bus_valid", 64'({bus0_valid, bus1_valid}), 64'd0);
        check_vec("fl_conflict", 64'(conflict_count), 64'd1);
        drive_slot(1, 2);
        drive_slot(3, 2);
        req_valid = 4'b1010;
        #1;
        check_vec("fl_ready_after", 64'(req_ready), 64'hF);
        tick();
        req_valid = 4'b0000;
        tick();
        check_vec("fl_ptr_b0src", 64'(bus0_src), 64'd1);
        check_vec("fl_ptr_b1src", 64'(bus1_src), 64'd3);
        check_vec("fl_ptr_valid", 64'({bus0_valid, bus1_valid}), 64'd3);
        check_vec("fl_value", 64'(bus1_value), 64'(exp_val(3, 2)));

        // Asynchronous reset with both buses active
        do_reset();
        for (int i = 0; i < 4; i++) drive_slot(i, 0);
        req_valid = 4'b1111;
        tick();
        tick();
        check_vec("ar_pre_valid", 64'({bus0_valid, bus1_valid}), 64'd3);
        #2;
        reset = 1'b0;
        req_valid = 4'b0000;
        #1;
        check_vec("ar_bus_valid", 64'({bus0_valid, bus1_valid}), 64'd0);
        check_vec("ar_bus0_value", 64'(bus0_value), 64'd0);
        check_vec("ar_bus1_tag", 64'(bus1_tag), 64'd0);
        check_vec("ar_conflict", 64'(conflict_count), 64'd0);
        check_vec("ar_ready", 64'(req_ready), 64'hF);
        #1;
        reset = 1'b1;
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0000;
        tick();
        check_vec("ar_first_b0src", 64'(bus0_src), 64'd0);
        check_vec("ar_first_b1src", 64'(bus1_src), 64'd3);
        check_vec("ar_first_valid", 64'({bus0_valid, bus1_valid}), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the two result broadcast buses (tag/value wakeup to rename, reservation station and LSQ; ROB-index completion to the ROB) among NUM_REQ result producers: the three functional units and the LSQ load-forward path. Each producer gets a one-entry holding buffer with a valid/ready handshake. A round-robin scheduler grants up to two buffered results per cycle onto registered bus outputs. This decouples the producers from bus contention, so no producer ever drops a result.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (index 0..2 = fu1..fu3, 3 = LSQ)
- TAG_W, 6, physical-register tag width
- ROB_W, 6, ROB index width
- DATA_W, 32, result value width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- flush  in  1  synchronous flush of all buffered and in-flight results
- req_valid  in  NUM_REQ  producer i presents a result
- req_ready  out  NUM_REQ  buffer i can accept this cycle
- req_tag  in  NUM_REQ*TAG_W  packed destination tags, slice i = [i*TAG_W +: TAG_W]
- req_rob  in  NUM_REQ*ROB_W  packed ROB indices
- req_value  in  NUM_REQ*DATA_W  packed result values
- bus0_valid, bus1_valid  out  1  broadcast slot active
- bus0_tag, bus1_tag  out  TAG_W  broadcast tag
- bus0_rob, bus1_rob  out  ROB_W  broadcast ROB index
- bus0_value, bus1_value  out  DATA_W  broadcast value
- bus0_src, bus1_src  out  2  producer index of the broadcast
- conflict_count  out  16  saturating count of cycles with more than 2 buffers occupied

## Operation
- State per producer: buf_valid, buf_tag, buf_rob, buf_value. Global state: round-robin pointer ptr (0..NUM_REQ-1) and conflict_count.
- Grant logic uses registered buffer state only, never req_valid, so there is no combinational path from req_valid to req_ready.
- Selection: scan indices ptr, ptr+1, … mod NUM_REQ. The first occupied buffer is grant A and goes to bus0. The next occupied buffer is grant B and goes to bus1. At most 2 grants per cycle.
- One grant only: it goes to bus0 and bus1_valid = 0 next cycle. No grants: both bus valids are 0 next cycle.
- req_ready[i] = !flush & (!buf_valid[i] | granted[i]). A granted buffer can be refilled on the same edge.
- Capture: on an edge with req_valid[i] & req_ready[i], the buffer loads tag/rob/value and buf_valid[i] = 1. Otherwise a granted buffer clears.
- Producers must hold req_valid and data stable until they see req_ready high. Data is sampled only on the accepting edge.
- Pointer update: ptr <= (last granted index + 1) mod NUM_REQ. It is unchanged on a cycle with no grant. This guarantees each occupied buffer is granted within ceil(NUM_REQ/2) cycles.
- conflict_count increments when more than 2 buffers are occupied. It saturates at 16'hFFFF and is cleared only by reset, not by flush.
- Flush (synchronous): on that edge all buf_valid, bus0_valid and bus1_valid go to 0 and ptr goes to 0. No capture and no grant take effect, and req_ready is 0 throughout the flush cycle.
- Reset (asynchronous, any time, including mid-transfer): all buf_valid = 0, both bus valid = 0, all bus tag/rob/value/src = 0, ptr = 0, conflict_count = 0.
  - After reset deasserts, req_ready = all ones.
  - Any buffered results are discarded.

## Timing
- Bus outputs are registered.
- Minimum latency: a result accepted at edge N is broadcast in the cycle after edge N+1, i.e. visible on bus0/bus1 for exactly one cycle starting at N+1.
- Throughput: 2 results per cycle sustained. A single producer sustains 1 result per cycle because of the same-edge refill.
- Bus valid pulses last exactly one cycle per result. The same result is never broadcast twice.
- Simultaneous flush and reset: reset wins.

## Test plan
- Reset then idle → all outputs 0, req_ready = 4'b1111, conflict_count = 0.
- fu1 only:
  - Stimulus: req_valid = 4'b0001 with tag 5, rob 3, value 32'hDEADBEEF, at edge N.
  - Required response: bus0_valid = 1 with tag 5, rob 3, value 32'hDEADBEEF, src 0 after edge N+1; bus1_valid = 0.
  - Continuous fu1 requests yield one broadcast every cycle.
- All four requesting every cycle from reset:
  - Grant order must be {0,1}, {2,3}, {0,1}, … with ptr returning to 0 each time.
  - conflict_count increments once per cycle while more than 2 buffers are occupied.
- Backpressure: buffers 0..3 full.
  - A new req_valid[3] is refused (req_ready[3] = 0) until buffer 3 is granted.
  - It is accepted on the grant edge, and no result is lost or duplicated.
- flush asserted with 3 buffers full → no bus_valid next cycle, ptr = 0, req_ready = 0 during the flush cycle.
- reset driven low mid-stream with both buses active → outputs clear immediately without waiting for a clock edge; the first post-reset grant starts at index 0.
